// File: rtl/enemy_ai.sv
// rtl/enemy_ai.sv - Enemy tank AI: spawn delay, random move segments, stuck turns, timed fire.
// Optional macro ENEMY_AI_CHASE_EN steers segment-expiry picks toward the player.
`timescale 1ns/1ps
module enemy_ai #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [3:0]  DIR_INIT     = 4'b0010,
  parameter int          SPAWN_DELAY  = 60,
  parameter int          MOVE_MIN     = 16,
  parameter int          STUCK_FRAMES = 4,
  parameter int          FIRE_PERIOD  = 90
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic       bullet_active,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic [3:0] ai_dir,
  output logic [1:0] ai_state
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam int SPAWN_W = $clog2(SPAWN_DELAY + 32);
  localparam int SEG_W   = $clog2(MOVE_MIN + 32);
  localparam int STUCK_W = $clog2(STUCK_FRAMES + 32);
  localparam int FIRE_W  = $clog2(FIRE_PERIOD + 32);

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    SPAWN_WAIT = 2'd0,
    MOVE       = 2'd1,
    TURN       = 2'd2,
    HOLD       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           dir_q, dir_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [SPAWN_W-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [SEG_W-1:0]     seg_cnt_q, seg_cnt_d;
  logic [STUCK_W-1:0]   stuck_cnt_q, stuck_cnt_d;
  logic [FIRE_W-1:0]    fire_cnt_q, fire_cnt_d;
  logic [9:0]           prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [3:0]           move_q, move_d;
  logic                 fire_q, fire_d;

  logic [3:0]           rand_dir, turn_dir, expiry_dir;
  logic [SEG_W-1:0]     seg_load;
  logic                 static_pos;

  function automatic logic [3:0] rotate_cw(input logic [3:0] d);
    case (d)
      DIR_UP:    rotate_cw = DIR_RIGHT;
      DIR_RIGHT: rotate_cw = DIR_DOWN;
      DIR_DOWN:  rotate_cw = DIR_LEFT;
      default:   rotate_cw = DIR_UP;
    endcase
  endfunction

  assign rand_dir   = 4'b0001 << lfsr_q[1:0];
  assign turn_dir   = (rand_dir == dir_q) ? rotate_cw(dir_q) : rand_dir;
  assign seg_load   = SEG_W'(MOVE_MIN) + SEG_W'(lfsr_q[4:0]);
  assign static_pos = (TankX == prev_x_q) && (TankY == prev_y_q);

`ifdef ENEMY_AI_CHASE_EN
  logic [9:0] dist_x, dist_y;
  always_comb begin
    dist_x     = (PlayerX >= TankX) ? (PlayerX - TankX) : (TankX - PlayerX);
    dist_y     = (PlayerY >= TankY) ? (PlayerY - TankY) : (TankY - PlayerY);
    expiry_dir = rand_dir;
    // Vertical wins ties; a zero distance on the chosen axis keeps the random pick.
    if (lfsr_q[2]) begin
      if (dist_x > dist_y)
        expiry_dir = (PlayerX > TankX) ? DIR_RIGHT : DIR_LEFT;
      else if (dist_y != 10'd0)
        expiry_dir = (PlayerY > TankY) ? DIR_DOWN : DIR_UP;
    end
  end
`else
  logic unused_player;
  assign unused_player = ^{PlayerX, PlayerY};
  assign expiry_dir    = rand_dir;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= SPAWN_WAIT;
      dir_q       <= DIR_INIT;
      lfsr_q      <= SEED_EFF;
      spawn_cnt_q <= '0;
      seg_cnt_q   <= '0;
      stuck_cnt_q <= '0;
      fire_cnt_q  <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      move_q      <= '0;
      fire_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      lfsr_q      <= lfsr_d;
      spawn_cnt_q <= spawn_cnt_d;
      seg_cnt_q   <= seg_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      fire_cnt_q  <= fire_cnt_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      move_q      <= move_d;
      fire_q      <= fire_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    lfsr_d      = lfsr_q;
    spawn_cnt_d = spawn_cnt_q;
    seg_cnt_d   = seg_cnt_q;
    stuck_cnt_d = stuck_cnt_q;
    fire_cnt_d  = fire_cnt_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    if (enable) begin
      lfsr_d   = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
      prev_x_d = TankX;
      prev_y_d = TankY;
      // A blocked shot parks the fire counter at zero until the bullet lands.
      if (state_q != SPAWN_WAIT) begin
        if (fire_cnt_q == '0) begin
          if (!bullet_active) fire_cnt_d = FIRE_W'(FIRE_PERIOD);
        end else begin
          fire_cnt_d = fire_cnt_q - FIRE_W'(1);
        end
      end
      case (state_q)
        SPAWN_WAIT: begin
          if (spawn_cnt_q == SPAWN_W'(SPAWN_DELAY - 1)) begin
            state_d    = MOVE;
            seg_cnt_d  = seg_load;
            fire_cnt_d = FIRE_W'(FIRE_PERIOD);
          end else begin
            spawn_cnt_d = spawn_cnt_q + SPAWN_W'(1);
          end
        end
        MOVE: begin
          stuck_cnt_d = static_pos ? (stuck_cnt_q + STUCK_W'(1)) : '0;
          if (static_pos && (stuck_cnt_q == STUCK_W'(STUCK_FRAMES - 1))) begin
            state_d     = TURN;
            stuck_cnt_d = '0;
          end else if (seg_cnt_q == '0) begin
            state_d     = HOLD;
            dir_d       = expiry_dir;
            stuck_cnt_d = '0;
          end else begin
            seg_cnt_d = seg_cnt_q - SEG_W'(1);
          end
        end
        TURN: begin
          state_d   = MOVE;
          dir_d     = turn_dir;
          seg_cnt_d = seg_load;
        end
        HOLD: begin
          state_d   = MOVE;
          seg_cnt_d = seg_load;
        end
        default: state_d = SPAWN_WAIT;
      endcase
    end
  end

  always_comb begin
    move_d = 4'b0000;
    fire_d = 1'b0;
    if (enable) begin
      if (state_d == MOVE) move_d = dir_d;
      fire_d = (state_q != SPAWN_WAIT) && (fire_cnt_q == '0) && !bullet_active;
    end
  end

  assign move_up    = move_q[0];
  assign move_down  = move_q[1];
  assign move_left  = move_q[2];
  assign move_right = move_q[3];
  assign fire       = fire_q;
  assign ai_dir     = dir_q;
  assign ai_state   = state_q;

endmodule

// File: tb/tb_enemy_ai.sv
// tb/tb_enemy_ai.sv - Self-checking bench for enemy_ai against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_enemy_ai;
  localparam int SPAWN_DELAY  = 60;
  localparam int MOVE_MIN     = 16;
  localparam int STUCK_FRAMES = 4;
  localparam int FIRE_PERIOD  = 90;
  localparam logic [3:0] DIR_INIT = 4'b0010;

  logic       frame_clk = 1'b0;
  logic       Reset, enable, bullet_active;
  logic [9:0] TankX, TankY, PlayerX, PlayerY;
  logic       move_up, move_down, move_left, move_right, fire;
  logic [3:0] ai_dir;
  logic [1:0] ai_state;

  enemy_ai dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable),
    .TankX(TankX), .TankY(TankY), .bullet_active(bullet_active),
    .PlayerX(PlayerX), .PlayerY(PlayerY),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .fire(fire), .ai_dir(ai_dir), .ai_state(ai_state)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;
  int frame  = 0;

  // Model: phase 0 spawn, 1 move, 2 turn, 3 hold
  int          m_phase, m_spawn_elapsed, m_seg_left, m_stuck, m_fire_wait;
  logic [3:0]  m_dir, m_move;
  logic [15:0] m_lfsr;
  logic [9:0]  m_px, m_py;
  logic        m_fire;

  function automatic logic [3:0] next_clockwise(input logic [3:0] d);
    logic [3:0] ring [4];
    ring[0] = 4'b0001; ring[1] = 4'b1000; ring[2] = 4'b0010; ring[3] = 4'b0100;
    for (int i = 0; i < 4; i++) if (ring[i] == d) return ring[(i + 1) % 4];
    return 4'b0001;
  endfunction

  function automatic logic [3:0] expiry_choice(input logic [15:0] r);
    logic [3:0] pick;
    pick = 4'b0001 << r[1:0];
`ifdef ENEMY_AI_CHASE_EN
    begin
      int dx, dy;
      dx = int'(PlayerX) - int'(TankX); if (dx < 0) dx = -dx;
      dy = int'(PlayerY) - int'(TankY); if (dy < 0) dy = -dy;
      if (r[2]) begin
        if (dx > dy) pick = (PlayerX > TankX) ? 4'b1000 : 4'b0100;
        else if (dy != 0) pick = (PlayerY > TankY) ? 4'b0010 : 4'b0001;
      end
    end
`endif
    return pick;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_spawn_elapsed = 0; m_seg_left = 0; m_stuck = 0; m_fire_wait = 0;
    m_dir = DIR_INIT; m_lfsr = 16'hACE1; m_px = '0; m_py = '0; m_move = '0; m_fire = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] cur;
    logic [3:0]  nd;
    cur = m_lfsr;
    if (!enable) begin
      m_move = '0; m_fire = 1'b0;
      return;
    end
    m_fire = 1'b0;
    if (m_phase != 0) begin
      if (m_fire_wait == 0) begin
        if (!bullet_active) begin m_fire = 1'b1; m_fire_wait = FIRE_PERIOD; end
      end else m_fire_wait = m_fire_wait - 1;
    end
    case (m_phase)
      0: begin
        m_spawn_elapsed = m_spawn_elapsed + 1;
        if (m_spawn_elapsed == SPAWN_DELAY) begin
          m_phase = 1; m_seg_left = MOVE_MIN + int'(cur[4:0]); m_fire_wait = FIRE_PERIOD;
        end
      end
      1: begin
        if (TankX == m_px && TankY == m_py) m_stuck = m_stuck + 1; else m_stuck = 0;
        if (m_stuck == STUCK_FRAMES) begin m_phase = 2; m_stuck = 0; end
        else if (m_seg_left == 0) begin m_dir = expiry_choice(cur); m_phase = 3; m_stuck = 0; end
        else m_seg_left = m_seg_left - 1;
      end
      2: begin
        nd = 4'b0001 << cur[1:0];
        if (nd == m_dir) nd = next_clockwise(m_dir);
        m_dir = nd; m_phase = 1; m_seg_left = MOVE_MIN + int'(cur[4:0]);
      end
      default: begin m_phase = 1; m_seg_left = MOVE_MIN + int'(cur[4:0]); end
    endcase
    m_px = TankX; m_py = TankY;
    m_lfsr = cur[0] ? ((cur >> 1) ^ 16'hB400) : (cur >> 1);
    m_move = (m_phase == 1) ? m_dir : 4'b0000;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s frame %0d: got %0h expected %0h", name, frame, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input logic cond, input logic [15:0] act);
    checks++;
    if (cond !== 1'b1) begin
      errors++;
      $display("FAIL %s frame %0d: value %0h violates condition", name, frame, act);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    if (Reset) model_reset(); else model_step();
    @(negedge frame_clk);
    frame++;
  endtask

  logic cmp_on = 1'b0;
  logic prev_fire = 1'b0;
  always @(negedge frame_clk) begin
    if (cmp_on) begin
      chk("model_move", {move_right, move_left, move_down, move_up}, m_move);
      chk("model_fire", fire, m_fire);
      chk("model_dir", ai_dir, m_dir);
      chk("model_state", ai_state, m_phase[1:0]);
      chk_true("fire_not_consecutive", !(fire && prev_fire), fire);
      prev_fire = fire;
    end
  end

  logic [3:0] saved_dir;
  bit found;

  initial begin
    Reset = 1'b1; enable = 1'b1; bullet_active = 1'b0;
    TankX = 10'd50; TankY = 10'd50; PlayerX = 10'd0; PlayerY = 10'd0;
    model_reset();
    cmp_on = 1'b1;
    repeat (3) tick();
    Reset = 1'b0; frame = 0;
    chk("reset_state", ai_state, 16'd0);
    chk("reset_dir", ai_dir, DIR_INIT);
    chk("reset_move", {move_right, move_left, move_down, move_up}, 16'd0);
    chk("reset_fire", fire, 16'd0);

    for (int f = 1; f <= 60; f++) begin
      tick();
      if (f < 60) chk("spawn_quiet", {fire, move_right, move_left, move_down, move_up}, 16'd0);
    end
    chk("spawn_exit_state", ai_state, 16'd1);
    chk("spawn_exit_move", {move_right, move_left, move_down, move_up}, 16'b0010);

    for (int f = 61; f <= 64; f++) tick();
    chk("stuck_turn_state", ai_state, 16'd2);
    chk("stuck_turn_move", {move_right, move_left, move_down, move_up}, 16'd0);

    for (int f = 65; f <= 300; f++) begin
      TankX = TankX + 10'd1;
      bullet_active = (f >= 100 && f <= 200);
      tick();
      if (f == 65) begin
        chk("turn_back_to_move", ai_state, 16'd1);
        chk_true("turn_dir_changed", ai_dir != 4'b0010, ai_dir);
      end
      if (f <= 200) chk("fire_blocked", fire, 16'd0);
      if (f == 201) chk("fire_after_bullet", fire, 16'd1);
      if (f == 291) chk("fire_before_reload", fire, 16'd0);
      if (f == 292) chk("fire_after_reload", fire, 16'd1);
    end

    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == 1 && m_seg_left >= 12) found = 1;
      else begin TankX = TankX + 10'd1; tick(); end
    end
    chk_true("wait_mid_segment", found, 16'(m_seg_left));
    saved_dir = m_dir;
    enable = 1'b0;
    repeat (10) begin
      tick();
      chk("disabled_quiet", {fire, move_right, move_left, move_down, move_up}, 16'd0);
    end
    enable = 1'b1;
    TankX = TankX + 10'd1;
    tick();
    chk("resume_state", ai_state, 16'd1);
    chk("resume_move", {move_right, move_left, move_down, move_up}, saved_dir);
    repeat (30) begin TankX = TankX + 10'd1; tick(); end

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      TankX = TankX + 10'd1;
      tick();
      if (m_fire) found = 1;
    end
    chk_true("wait_fire_pulse", found, 16'(fire));
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_fire", fire, 16'd0);
    chk("async_reset_state", ai_state, 16'd0);
    chk("async_reset_dir", ai_dir, DIR_INIT);
    repeat (2) tick();
    Reset = 1'b0; frame = 0;
    for (int f = 1; f <= 64; f++) begin
      tick();
      if (f == 60) chk("respawn_move", {move_right, move_left, move_down, move_up}, 16'b0010);
    end
    chk("restuck_turn", ai_state, 16'd2);
    repeat (5) tick();

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
